// File: rtl/aurora_test_if.sv
// aurora_test_if -- user-side bundle of the aurora_test lane.
//   TX_*   : 16-bit transmit word stream (bit 0 = MSB) with keep/last
//   RX_*   : received word stream, RX_TVALID_I is a one-cycle pulse
//   *_ERR_I: one-cycle error pulses
//   LANE_UP_I / CHANNEL_UP_I: link status
//   LOCAL_*: handshake taps for latency measurement
// Modports: slave = the lane, master = the user logic driving it.
interface aurora_test_if;
  logic [0:15] TX_TDATA_I;
  logic        TX_TVALID_I;
  logic        TX_TREADY_I;
  logic [0:1]  TX_TKEEP_I;
  logic        TX_TLAST_I;
  logic [0:15] RX_TDATA_I;
  logic        RX_TVALID_I;
  logic [0:1]  RX_TKEEP_I;
  logic        RX_TLAST_I;
  logic        HARD_ERR_I;
  logic        SOFT_ERR_I;
  logic        FRAME_ERR_I;
  logic        LANE_UP_I;
  logic        CHANNEL_UP_I;
  logic        LOCAL_TX_TVALID_OUT;
  logic        LOCAL_RX_TVALID_OUT;

  modport slave (
    input  TX_TDATA_I, TX_TVALID_I, TX_TKEEP_I, TX_TLAST_I,
    output TX_TREADY_I,
    output RX_TDATA_I, RX_TVALID_I, RX_TKEEP_I, RX_TLAST_I,
    output HARD_ERR_I, SOFT_ERR_I, FRAME_ERR_I,
    output LANE_UP_I, CHANNEL_UP_I,
    output LOCAL_TX_TVALID_OUT, LOCAL_RX_TVALID_OUT
  );

  modport master (
    output TX_TDATA_I, TX_TVALID_I, TX_TKEEP_I, TX_TLAST_I,
    input  TX_TREADY_I,
    input  RX_TDATA_I, RX_TVALID_I, RX_TKEEP_I, RX_TLAST_I,
    input  HARD_ERR_I, SOFT_ERR_I, FRAME_ERR_I,
    input  LANE_UP_I, CHANNEL_UP_I,
    input  LOCAL_TX_TVALID_OUT, LOCAL_RX_TVALID_OUT
  );
endinterface

// File: rtl/aurora_test.sv
// aurora_test -- single-bit serial lane with symbol framing, alignment and
// error detection.
// Ports:
//   GT_REFCLK1 : sole clock, rising edge
//   RESET      : asynchronous, active-high
//   RXP / RXN  : serial receive (only RXP is sampled)
//   TXP / TXN  : serial transmit, TXP registered, TXN = ~TXP
//   user       : aurora_test_if.slave word streams and status
// Symbol (22 bits, first bit on the wire first):
//   sync(1,0) type(1=data) last keep[0] keep[1] data[0..15]
// Option: define AURORA_LOOPBACK_EN to feed the receiver from the internal
// TXP instead of RXP.
module aurora_test #(
  parameter int ALIGN_COUNT = 4
) (
  input  logic          GT_REFCLK1,
  input  logic          RESET,
  input  logic          RXP,
  input  logic          RXN,
  output logic          TXP,
  output logic          TXN,
  aurora_test_if.slave  user
);

  localparam logic [21:0] SYM_IDLE  = {2'b10, 4'b0000, 16'hBC1C};
  localparam logic [21:0] SYM_READY = {2'b10, 4'b0000, 16'hBC7C};
  localparam int          GW        = $clog2(ALIGN_COUNT + 1);

  typedef enum logic [1:0] {HUNT, ALIGN, UP} rx_state_t;

  // ---------------------------------------------------------------- TX
  logic [21:0] tx_sym;     // current symbol, shifted out MSB first
  logic [4:0]  tx_cnt;     // bit slot being emitted this cycle
  logic [21:0] tx_next;
  logic        tx_ready;
  logic        lane_up;
  logic        last_ready;
  logic        chan_up;

  assign chan_up  = lane_up & last_ready;
  assign tx_ready = chan_up & (tx_cnt == 5'd21);

  always_comb begin
    tx_next = lane_up ? SYM_READY : SYM_IDLE;
    if (tx_ready && user.TX_TVALID_I)
      tx_next = {2'b10, 1'b1, user.TX_TLAST_I, user.TX_TKEEP_I, user.TX_TDATA_I};
  end

  always_ff @(posedge GT_REFCLK1 or posedge RESET) begin
    if (RESET) begin
      tx_sym <= SYM_IDLE;
      tx_cnt <= 5'd0;
      TXP    <= 1'b0;
    end else begin
      TXP <= tx_sym[21];
      if (tx_cnt == 5'd21) begin
        tx_cnt <= 5'd0;
        tx_sym <= tx_next;
      end else begin
        tx_cnt <= tx_cnt + 5'd1;
        tx_sym <= {tx_sym[20:0], 1'b0};
      end
    end
  end

  assign TXN = ~TXP;

  // ---------------------------------------------------------------- RX
  logic rx_bit;
  logic rx_unused;

`ifdef AURORA_LOOPBACK_EN
  assign rx_bit    = TXP;
  assign rx_unused = RXP ^ RXN;
`else
  assign rx_bit    = RXP;
  assign rx_unused = RXN;
`endif

  logic [20:0]   rx_sr;
  logic [21:0]   rx_sym;   // the 22 most recent bits, including this cycle's
  rx_state_t     state;
  logic [4:0]    rx_cnt;
  logic [GW-1:0] good_cnt;
  logic [1:0]    bad_sync_cnt;
  logic [15:0]   rx_data;
  logic [1:0]    rx_keep;
  logic          rx_last;
  logic          rx_valid;
  logic          soft_err;
  logic          hard_err;
  logic          frame_err;

  assign rx_sym = {rx_sr, rx_bit};

  logic        sync_ok, is_data, sym_last, is_idle, is_ready, good_ctrl;
  logic        hunt_hit, frame_bad;
  logic [1:0]  sym_keep;
  logic [15:0] payload;

  assign sync_ok   = (rx_sym[21:20] == 2'b10);
  assign is_data   = rx_sym[19];
  assign sym_last  = rx_sym[18];
  assign sym_keep  = rx_sym[17:16];
  assign payload   = rx_sym[15:0];
  assign is_idle   = (payload == SYM_IDLE[15:0]);
  assign is_ready  = (payload == SYM_READY[15:0]);
  assign good_ctrl = sync_ok & ~is_data & ~sym_last & (sym_keep == 2'b00) & (is_idle | is_ready);
  assign hunt_hit  = (rx_sym == SYM_IDLE) || (rx_sym == SYM_READY);
  assign frame_bad = (~sym_last & (sym_keep != 2'b11)) | (sym_last & (sym_keep == 2'b00));

  // Symbols are judged on the edge that samples their final bit, so every
  // RX output pulse lands in the cycle right after that bit.
  always_ff @(posedge GT_REFCLK1 or posedge RESET) begin
    if (RESET) begin
      rx_sr        <= '0;
      state        <= HUNT;
      rx_cnt       <= 5'd0;
      good_cnt     <= '0;
      bad_sync_cnt <= 2'd0;
      lane_up      <= 1'b0;
      last_ready   <= 1'b0;
      rx_data      <= 16'd0;
      rx_keep      <= 2'd0;
      rx_last      <= 1'b0;
      rx_valid     <= 1'b0;
      soft_err     <= 1'b0;
      hard_err     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_sr     <= rx_sym[20:0];
      rx_valid  <= 1'b0;
      soft_err  <= 1'b0;
      hard_err  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        HUNT: begin
          if (hunt_hit) begin
            state      <= ALIGN;
            rx_cnt     <= 5'd0;
            good_cnt   <= '0;
            last_ready <= is_ready;
          end
        end
        ALIGN: begin
          if (rx_cnt == 5'd21) begin
            rx_cnt <= 5'd0;
            if (good_ctrl) begin
              last_ready <= is_ready;
              if (good_cnt == GW'(ALIGN_COUNT - 1)) begin
                state        <= UP;
                lane_up      <= 1'b1;
                bad_sync_cnt <= 2'd0;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else begin
              state <= HUNT;
            end
          end else begin
            rx_cnt <= rx_cnt + 5'd1;
          end
        end
        UP: begin
          if (rx_cnt == 5'd21) begin
            rx_cnt <= 5'd0;
            if (!sync_ok) begin
              soft_err <= 1'b1;
              if (bad_sync_cnt == 2'd3) begin
                hard_err   <= 1'b1;
                lane_up    <= 1'b0;
                last_ready <= 1'b0;
                state      <= HUNT;
              end else begin
                bad_sync_cnt <= bad_sync_cnt + 2'd1;
              end
            end else begin
              bad_sync_cnt <= 2'd0;
              if (!is_data) begin
                if (is_idle || is_ready) last_ready <= is_ready;
                else                     soft_err   <= 1'b1;
              end else if (frame_bad) begin
                frame_err <= 1'b1;
              end else if (chan_up) begin
                rx_valid <= 1'b1;
                rx_data  <= payload;
                rx_keep  <= sym_keep;
                rx_last  <= sym_last;
              end
            end
          end else begin
            rx_cnt <= rx_cnt + 5'd1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign user.TX_TREADY_I         = tx_ready;
  assign user.RX_TDATA_I          = rx_data;
  assign user.RX_TVALID_I         = rx_valid;
  assign user.RX_TKEEP_I          = rx_keep;
  assign user.RX_TLAST_I          = rx_last;
  assign user.HARD_ERR_I          = hard_err;
  assign user.SOFT_ERR_I          = soft_err;
  assign user.FRAME_ERR_I         = frame_err;
  assign user.LANE_UP_I           = lane_up;
  assign user.CHANNEL_UP_I        = chan_up;
  assign user.LOCAL_TX_TVALID_OUT = user.TX_TVALID_I & tx_ready;
  assign user.LOCAL_RX_TVALID_OUT = rx_valid;

endmodule

// File: tb/tb_aurora_test.sv
// tb_aurora_test -- two cross-connected lanes (or one lane in loopback when
// AURORA_LOOPBACK_EN is defined). Words sent are pushed into the receiving
// side's expected queue; a negedge monitor pops and compares every
// RX_TVALID_I pulse and tallies error pulses.
module tb_aurora_test;

`ifdef AURORA_LOOPBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_txp, a_txn, b_txp, b_txn, b_rx;
  logic force_b_low = 1'b0;
  assign b_rx = force_b_low ? 1'b0 : a_txp;

  aurora_test_if ia();
  aurora_test_if ib();

  aurora_test #(.ALIGN_COUNT(4)) u_a (
    .GT_REFCLK1(clk), .RESET(rst), .RXP(b_txp), .RXN(b_txn),
    .TXP(a_txp), .TXN(a_txn), .user(ia));

  aurora_test #(.ALIGN_COUNT(4)) u_b (
    .GT_REFCLK1(clk), .RESET(rst), .RXP(b_rx), .RXN(~b_rx),
    .TXP(b_txp), .TXN(b_txn), .user(ib));

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
  } word_t;

  word_t q_a[$];
  word_t q_b[$];
  int checks = 0, fails = 0;
  int soft_a = 0, hard_a = 0, frame_a = 0, rxn_a = 0;
  int soft_b = 0, hard_b = 0, frame_b = 0, rxn_b = 0;
  int exp_frame_a = 0, exp_frame_b = 0;
  word_t got_a, got_b, exp_a, exp_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (ia.SOFT_ERR_I)  soft_a++;
      if (ia.HARD_ERR_I)  hard_a++;
      if (ia.FRAME_ERR_I) frame_a++;
      if (ib.SOFT_ERR_I)  soft_b++;
      if (ib.HARD_ERR_I)  hard_b++;
      if (ib.FRAME_ERR_I) frame_b++;
      if (ia.RX_TVALID_I) begin
        rxn_a++;
        got_a = {ia.RX_TDATA_I, ia.RX_TKEEP_I, ia.RX_TLAST_I};
        if (q_a.size() == 0) begin
          checks++; fails++;
          $display("FAIL a_rx_unexpected: got %0h expected none", got_a);
        end else begin
          exp_a = q_a.pop_front();
          chk("a_rx_word", got_a, exp_a);
        end
        chk("a_local_rx", ia.LOCAL_RX_TVALID_OUT, 1);
      end
      if (ib.RX_TVALID_I) begin
        rxn_b++;
        got_b = {ib.RX_TDATA_I, ib.RX_TKEEP_I, ib.RX_TLAST_I};
        if (q_b.size() == 0) begin
          checks++; fails++;
          $display("FAIL b_rx_unexpected: got %0h expected none", got_b);
        end else begin
          exp_b = q_b.pop_front();
          chk("b_rx_word", got_b, exp_b);
        end
        chk("b_local_rx", ib.LOCAL_RX_TVALID_OUT, 1);
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // Reference rule: a data word is delivered unless its last/keep pair is
  // illegal, in which case the receiver reports a frame error instead.
  task automatic send(input bit side, input word_t w);
    int  n;
    bit  rdy;
    bit  dst;
    bit  legal;
    n   = 0;
    rdy = 1'b0;
    if (side) begin
      ib.TX_TDATA_I = w.d; ib.TX_TKEEP_I = w.k; ib.TX_TLAST_I = w.l; ib.TX_TVALID_I = 1'b1;
    end else begin
      ia.TX_TDATA_I = w.d; ia.TX_TKEEP_I = w.k; ia.TX_TLAST_I = w.l; ia.TX_TVALID_I = 1'b1;
    end
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
      rdy = side ? ib.TX_TREADY_I : ia.TX_TREADY_I;
    end
    if (!rdy) begin
      checks++; fails++;
      $display("FAIL tx_ready_timeout: side %0d got no ready expected ready within 100", side);
    end else begin
      chk("local_tx_pulse", side ? ib.LOCAL_TX_TVALID_OUT : ia.LOCAL_TX_TVALID_OUT, 1);
      dst   = LOOP ? side : ~side;
      legal = !((!w.l && w.k != 2'b11) || (w.l && w.k == 2'b00));
      if (legal) begin
        if (dst) q_b.push_back(w); else q_a.push_back(w);
      end else begin
        if (dst) exp_frame_b++; else exp_frame_a++;
      end
    end
    @(posedge clk);
    #1;
    if (side) ib.TX_TVALID_I = 1'b0; else ia.TX_TVALID_I = 1'b0;
  endtask

  task automatic rand_traffic(input bit side, input int cnt);
    word_t w;
    for (int i = 0; i < cnt; i++) begin
      w.d = 16'($urandom);
      w.l = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) w.k = w.l ? 2'b00 : 2'($urandom_range(0, 2));
      else                           w.k = w.l ? 2'($urandom_range(1, 3)) : 2'b11;
      send(side, w);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
  endtask

  task automatic wait_up(input string name, input bit both);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      ok = ia.LANE_UP_I && ia.CHANNEL_UP_I;
      if (both) ok = ok && ib.LANE_UP_I && ib.CHANNEL_UP_I;
    end
    chk(name, ok, 1);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [21:0] first_sym;
  int          early_ready;
  word_t       wv;

  initial begin
    ia.TX_TDATA_I = 16'h5555; ia.TX_TKEEP_I = 2'b11; ia.TX_TLAST_I = 1'b0; ia.TX_TVALID_I = 1'b1;
    ib.TX_TDATA_I = 16'h0;    ib.TX_TKEEP_I = 2'b00; ib.TX_TLAST_I = 1'b0; ib.TX_TVALID_I = 1'b0;
    rst = 1'b1;
    repeat (125) @(negedge clk);
    chk("reset_outputs_a",
        {a_txp, a_txn, ia.TX_TREADY_I, ia.RX_TVALID_I, ia.RX_TDATA_I, ia.RX_TKEEP_I,
         ia.RX_TLAST_I, ia.HARD_ERR_I, ia.SOFT_ERR_I, ia.FRAME_ERR_I, ia.LANE_UP_I,
         ia.CHANNEL_UP_I, ia.LOCAL_TX_TVALID_OUT, ia.LOCAL_RX_TVALID_OUT},
        {1'b0, 1'b1, 28'd0});
    chk("reset_txn_b", {b_txp, b_txn, ib.LANE_UP_I, ib.CHANNEL_UP_I}, 4'b0100);
    rst = 1'b0;

    // TX_TVALID_I is held high on side a well before the link can be up.
    early_ready = 0;
    first_sym   = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i < 22) first_sym[21 - i] = a_txp;
      if (ia.TX_TREADY_I || ia.LOCAL_TX_TVALID_OUT) early_ready++;
    end
    ia.TX_TVALID_I = 1'b0;
    chk("first_symbol_idle", first_sym, {2'b10, 4'b0000, 16'hBC1C});
    chk("no_ready_before_up", early_ready, 0);

    if (LOOP) begin
      wait_up("loopback_link_up", 1'b0);
      wv = '{d: 16'h1234, k: 2'b11, l: 1'b1};
      send(1'b0, wv);
      drain();
      chk("loopback_rx_count", rxn_a, 1);
    end else begin
      wait_up("link_up_200", 1'b1);
      chk("no_err_at_link_up", soft_a + hard_a + frame_a + soft_b + hard_b + frame_b, 0);

      wv = '{d: 16'hCAFE, k: 2'b11, l: 1'b0};
      send(1'b0, wv);
      wv = '{d: 16'hBABE, k: 2'b11, l: 1'b1};
      send(1'b0, wv);
      drain();
      chk("cafe_babe_count", rxn_b, 2);

      wv = '{d: 16'h0F0F, k: 2'b00, l: 1'b1};
      send(1'b0, wv);
      repeat (60) @(negedge clk);
      chk("frame_err_keep00", frame_b, 1);
      chk("frame_err_no_rx", rxn_b, 2);

      fork
        rand_traffic(1'b0, 14);
        rand_traffic(1'b1, 14);
      join
      drain();
      chk("frame_err_count_a", frame_a, exp_frame_a);
      chk("frame_err_count_b", frame_b, exp_frame_b);
      chk("no_soft_hard_traffic", soft_a + hard_a + soft_b + hard_b, 0);

      // Hold b's receive line low until its lane gives up.
      force_b_low = 1'b1;
      begin
        int n;
        n = 0;
        while (ib.LANE_UP_I && n < 200) begin
          @(negedge clk);
          n++;
        end
      end
      force_b_low = 1'b0;
      repeat (2) @(negedge clk);
      chk("fault_lane_dropped", ib.LANE_UP_I, 0);
      chk("fault_soft_err", soft_b > 0, 1);
      chk("fault_hard_err", hard_b, 1);
      wait_up("realign_200", 1'b1);
      chk("a_unaffected_errs", soft_a + hard_a, 0);

      wv = '{d: 16'hA5C3, k: 2'b01, l: 1'b1};
      send(1'b1, wv);
      wv = '{d: 16'h3C5A, k: 2'b11, l: 1'b1};
      send(1'b0, wv);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
